// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard controller.
//   - stage_e      : stage indices. The stall mask bit k belongs to stage k.
//   - DEF_*        : default geometry used by pipe_ctrl.
//   - cnt_width()  : number of bits needed to hold a value 0..max_val (minimum 1).
package pipe_ctrl_pkg;

    typedef enum int {
        STAGE_PC  = 0,
        STAGE_IF  = 1,
        STAGE_ID  = 2,
        STAGE_EX  = 3,
        STAGE_MEM = 4,
        STAGE_WB  = 5
    } stage_e;

    localparam int          DEF_NUM_STAGES  = 6;
    localparam int          DEF_FLUSH_STAGE = int'(STAGE_EX);
    localparam int          DEF_ADDR_W      = 32;
    localparam int unsigned DEF_TIMEOUT     = 1023;
    localparam int          DEF_CNT_W       = 32;

    // Smallest width that can represent max_val. It never returns 0, so a
    // disabled watchdog (max_val = 0) still gets a legal 1-bit counter.
    function automatic int cnt_width(input longint unsigned max_val);
        int w;
        w = 1;
        while ((w < 63) && ((64'd1 << w) <= max_val)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that stops at MAX instead of wrapping.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset, clears q
//     inc  : count up by one at the next edge (ignored once q == MAX)
//     clr  : clear q at the next edge; takes priority over inc
//     q    : current count
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline stall / flush controller.
//
//   Every stage k >= 1 may request a stall. The highest requesting stage k
//   freezes itself and every stage in front of it, so stall = ones in [k:0].
//   FLUSH_STAGE may request a flush/redirect. The flush kills the stages in
//   front of it, so stall requests at or below FLUSH_STAGE are dropped while
//   it is in effect. A stall from a stage behind FLUSH_STAGE (hi_stall)
//   freezes the flushing stage itself; its flush is then parked in a
//   one-entry pending slot and issued on the first cycle the back end frees up.
//
//   A saturating counter totals all stalled cycles. A second one counts
//   consecutive stalled cycles and trips a sticky watchdog flag when it
//   reaches TIMEOUT (TIMEOUT = 0 disables the watchdog).
//
//   Ports:
//     clk           : rising-edge clock
//     rst           : synchronous active-high reset
//     stallreq      : [NUM_STAGES-1:1] stall request per stage
//     flush_req     : flush/redirect request from FLUSH_STAGE
//     flush_pc      : redirect target, valid with flush_req
//     stall         : [NUM_STAGES-1:0] per-stage hold mask (combinational)
//     flush         : kill stages 0..FLUSH_STAGE-1 and redirect the PC (combinational)
//     new_pc        : redirect target while flush = 1, else 0
//     stall_timeout : sticky watchdog flag
//     stall_cycles  : number of cycles with stall != 0 (saturating)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          NUM_STAGES  = DEF_NUM_STAGES,
    parameter int          FLUSH_STAGE = DEF_FLUSH_STAGE,
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:1] stallreq,
    input  logic                  flush_req,
    input  logic [ADDR_W-1:0]     flush_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [ADDR_W-1:0]     new_pc,
    output logic                  stall_timeout,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int TO_W = cnt_width(longint'(TIMEOUT));

    // Flush parked behind a back-end stall, and where it redirects to.
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;

    // Sticky watchdog flag. It has to outlive the consecutive-stall count,
    // which clears on the first free cycle.
    logic timeout_flag;

    logic                  hi_stall;
    logic                  flush_eff;
    logic [NUM_STAGES-1:0] req_eff;
    logic [NUM_STAGES-1:0] stall_mask;
    logic                  stall_any;
    logic                  timeout_hit;
    logic [CNT_W-1:0]      total_q;
    logic [TO_W-1:0]       consec_q;

    // Stages behind the flushing stage hold it in place, which blocks the flush.
    always_comb begin
        hi_stall = 1'b0;
        for (int j = FLUSH_STAGE + 1; j < NUM_STAGES; j++) begin
            hi_stall = hi_stall | stallreq[j];
        end
    end

    assign flush_eff = (flush_req | pend) & ~hi_stall & ~rst;

    // Stage 0 never requests a stall. A live flush drops the requests from
    // the stages it is about to kill (and from the flushing stage itself).
    always_comb begin
        req_eff = {stallreq, 1'b0};
        if (flush_eff) begin
            for (int j = 0; j <= FLUSH_STAGE; j++) begin
                req_eff[j] = 1'b0;
            end
        end
    end

    // Thermometer mask: each bit is set if its own stage or any later stage
    // requests a stall.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        stall_mask = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            seen          = seen | req_eff[i];
            stall_mask[i] = seen;
        end
    end

    assign stall     = rst ? '0 : stall_mask;
    assign stall_any = |stall;
    assign flush     = flush_eff;

    always_comb begin
        new_pc = '0;
        if (flush_eff) begin
            new_pc = flush_req ? flush_pc : pend_pc;
        end
    end

    // A blocked flush is parked, and a newer blocked one replaces the parked
    // target. A flush that actually issues empties the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (flush_req && hi_stall) begin
            pend    <= 1'b1;
            pend_pc <= flush_pc;
        end else if (flush_eff) begin
            pend    <= 1'b0;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   ({CNT_W{1'b1}})
    ) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any),
        .clr   (1'b0),
        .q     (total_q)
    );

    sat_counter #(
        .WIDTH (TO_W),
        .MAX   (TO_W'(TIMEOUT))
    ) u_consec_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any),
        .clr   (~stall_any),
        .q     (consec_q)
    );

    // The flag is set on the same edge that the consecutive count reaches
    // TIMEOUT, so compare against TIMEOUT-1 while still stalling.
    assign timeout_hit = (TIMEOUT != 0) && stall_any
                         && (consec_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end
    end

    assign stall_timeout = timeout_flag & ~rst;
    assign stall_cycles  = rst ? '0 : total_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Two controllers share one set of inputs: dut_a uses the default geometry,
//   and dut_b uses TIMEOUT=4 and CNT_W=3 so that the watchdog and saturation
//   limits are reachable. A reference model in the bench predicts every
//   output each cycle.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int NS   = 6;
    localparam int FS   = 3;
    localparam int TO_B = 4;
    localparam int CW_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NS-1:1] stallreq;
    logic          flush_req;
    logic [31:0]   flush_pc;

    logic [NS-1:0]   stall_a, stall_b;
    logic            flush_a, flush_b;
    logic [31:0]     new_pc_a, new_pc_b;
    logic            timeout_a, timeout_b;
    logic [31:0]     cycles_a;
    logic [CW_B-1:0] cycles_b;

    pipe_ctrl dut_a (
        .clk           (clk),
        .rst           (rst),
        .stallreq      (stallreq),
        .flush_req     (flush_req),
        .flush_pc      (flush_pc),
        .stall         (stall_a),
        .flush         (flush_a),
        .new_pc        (new_pc_a),
        .stall_timeout (timeout_a),
        .stall_cycles  (cycles_a)
    );

    pipe_ctrl #(
        .TIMEOUT (TO_B),
        .CNT_W   (CW_B)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .stallreq      (stallreq),
        .flush_req     (flush_req),
        .flush_pc      (flush_pc),
        .stall         (stall_b),
        .flush         (flush_b),
        .new_pc        (new_pc_b),
        .stall_timeout (timeout_b),
        .stall_cycles  (cycles_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state. Index 0 models dut_a, index 1 models dut_b.
    bit              m_pend;
    logic [31:0]     m_pend_pc;
    longint unsigned m_cnt [2];
    longint unsigned m_cons [2];
    bit              m_flag [2];

    // Outputs the model predicts for the current cycle.
    logic [NS-1:0] e_stall;
    bit            e_flush;
    bit            e_hi;
    logic [31:0]   e_new_pc;

    typedef struct {
        logic [NS-1:1] sr;
        logic          fr;
        logic [31:0]   fp;
        logic [NS-1:0] stall;
        logic          flush;
        logic [31:0]   pc;
    } vec_t;

    vec_t vecs [9];

    function automatic longint unsigned cntMax(input int d);
        return (d == 0) ? 64'hFFFF_FFFF : ((64'd1 << CW_B) - 1);
    endfunction

    function automatic longint unsigned timeoutOf(input int d);
        return (d == 0) ? 64'd1023 : 64'(TO_B);
    endfunction

    task automatic checkValue(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelEval();
        int top;
        e_hi = 1'b0;
        for (int j = FS + 1; j < NS; j++) begin
            if (stallreq[j]) e_hi = 1'b1;
        end
        e_flush = !rst && (flush_req || m_pend) && !e_hi;
        top = 0;
        for (int k = 1; k < NS; k++) begin
            if (stallreq[k] && !(e_flush && k <= FS)) top = k;
        end
        if (rst || top == 0) e_stall = '0;
        else e_stall = NS'((64'd1 << (top + 1)) - 1);
        e_new_pc = e_flush ? (flush_req ? flush_pc : m_pend_pc) : 32'h0;
    endtask

    task automatic modelAdvance();
        if (rst) begin
            m_pend    = 1'b0;
            m_pend_pc = '0;
            for (int d = 0; d < 2; d++) begin
                m_cnt[d]  = 0;
                m_cons[d] = 0;
                m_flag[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (e_stall != 0) begin
                    if (m_cnt[d] < cntMax(d)) m_cnt[d]++;
                    if (m_cons[d] < timeoutOf(d)) m_cons[d]++;
                    if (timeoutOf(d) != 0 && m_cons[d] == timeoutOf(d)) m_flag[d] = 1'b1;
                end else begin
                    m_cons[d] = 0;
                end
            end
            if (flush_req && e_hi) begin
                m_pend    = 1'b1;
                m_pend_pc = flush_pc;
            end else if (e_flush) begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NS-1:1] sr, input logic fr, input logic [31:0] fp);
        @(negedge clk);
        rst       = r;
        stallreq  = sr;
        flush_req = fr;
        flush_pc  = fp;
        #1;
        modelEval();
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " stall_a"},   stall_a,   e_stall);
        checkValue({tag, " flush_a"},   flush_a,   e_flush);
        checkValue({tag, " new_pc_a"},  new_pc_a,  e_new_pc);
        checkValue({tag, " timeout_a"}, timeout_a, rst ? 0 : m_flag[0]);
        checkValue({tag, " cycles_a"},  cycles_a,  rst ? 0 : m_cnt[0]);
        checkValue({tag, " stall_b"},   stall_b,   e_stall);
        checkValue({tag, " flush_b"},   flush_b,   e_flush);
        checkValue({tag, " timeout_b"}, timeout_b, rst ? 0 : m_flag[1]);
        checkValue({tag, " cycles_b"},  cycles_b,  rst ? 0 : m_cnt[1]);
    endtask

    task automatic stepCycle(input string tag, input logic r, input logic [NS-1:1] sr, input logic fr, input logic [31:0] fp);
        applyStimulus(r, sr, fr, fp);
        checkOutput(tag);
        modelAdvance();
    endtask

    task automatic resetFor(input int n);
        for (int i = 0; i < n; i++) stepCycle("reset", 1'b1, '1, 1'b1, 32'hDEAD_BEEF);
    endtask

    initial begin
        rst       = 1'b1;
        stallreq  = '0;
        flush_req = 1'b0;
        flush_pc  = '0;
        m_pend    = 1'b0;
        m_pend_pc = '0;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_cons[d] = 0;
            m_flag[d] = 1'b0;
        end

        vecs[0] = '{5'b00100, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0};
        vecs[1] = '{5'b00010, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0};
        vecs[2] = '{5'b01010, 1'b0, 32'h0,        6'b011111, 1'b0, 32'h0};
        vecs[3] = '{5'b00010, 1'b1, 32'h100,      6'b000000, 1'b1, 32'h100};
        vecs[4] = '{5'b00000, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};
        vecs[5] = '{5'b10000, 1'b0, 32'h0,        6'b111111, 1'b0, 32'h0};
        vecs[6] = '{5'b00001, 1'b0, 32'h0,        6'b000011, 1'b0, 32'h0};
        vecs[7] = '{5'b00100, 1'b1, 32'h3C,       6'b000000, 1'b1, 32'h3C};
        vecs[8] = '{5'b00101, 1'b1, 32'hCAFE_0044, 6'b000000, 1'b1, 32'hCAFE_0044};

        // Reset forces every output low, even with requests active.
        applyStimulus(1'b1, '1, 1'b1, 32'h1234_5678);
        checkValue("rst stall",   stall_a,   0);
        checkValue("rst flush",   flush_a,   0);
        checkValue("rst new_pc",  new_pc_a,  0);
        checkValue("rst timeout", timeout_a, 0);
        checkValue("rst cycles",  cycles_a,  0);
        modelAdvance();
        resetFor(1);

        $display("[TB] single-cycle vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, vecs[i].sr, vecs[i].fr, vecs[i].fp);
            checkValue($sformatf("vec%0d stall", i),  stall_a,  vecs[i].stall);
            checkValue($sformatf("vec%0d flush", i),  flush_a,  vecs[i].flush);
            checkValue($sformatf("vec%0d new_pc", i), new_pc_a, vecs[i].pc);
            checkOutput($sformatf("vec%0d", i));
            modelAdvance();
        end

        $display("[TB] flush held off by back-end stall");
        resetFor(2);
        for (int i = 0; i < 3; i++) begin
            stepCycle("held", 1'b0, 5'b01000, (i == 0), (i == 0) ? 32'h200 : 32'h0);
            checkValue("held stall", stall_a, 6'b011111);
            checkValue("held flush", flush_a, 0);
        end
        stepCycle("release", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("release flush",  flush_a,  1);
        checkValue("release new_pc", new_pc_a, 32'h200);
        checkValue("release stall",  stall_a,  0);
        stepCycle("after", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("after flush", flush_a, 0);

        $display("[TB] watchdog trips on 4 consecutive stalls");
        resetFor(1);
        for (int i = 0; i < 4; i++) stepCycle("wd run", 1'b0, 5'b00001, 1'b0, 32'h0);
        stepCycle("wd drop", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("wd set", timeout_b, 1);
        stepCycle("wd hold", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("wd sticky", timeout_b, 1);

        $display("[TB] watchdog ignores broken stall runs");
        resetFor(1);
        for (int i = 0; i < 7; i++) stepCycle("wd gap", 1'b0, (i == 3) ? 5'b00000 : 5'b00001, 1'b0, 32'h0);
        stepCycle("wd gap end", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("wd gap clear", timeout_b, 0);

        $display("[TB] stall counter saturation");
        resetFor(1);
        for (int i = 0; i < 10; i++) stepCycle("sat run", 1'b0, 5'b00010, 1'b0, 32'h0);
        stepCycle("sat end", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("sat value", cycles_b, 7);
        checkValue("sat total", cycles_a, 10);
        stepCycle("sat hold", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("sat holds", cycles_b, 7);

        $display("[TB] reset discards a pending flush");
        resetFor(1);
        stepCycle("pend set", 1'b0, 5'b01000, 1'b1, 32'h200);
        stepCycle("pend wait", 1'b0, 5'b01000, 1'b0, 32'h0);
        stepCycle("pend rst", 1'b1, 5'b01000, 1'b0, 32'h0);
        stepCycle("pend gone", 1'b0, 5'b00000, 1'b0, 32'h0);
        checkValue("pend flush",   flush_a,   0);
        checkValue("pend cycles",  cycles_a,  0);
        checkValue("pend timeout", timeout_a, 0);

        $display("[TB] randomized traffic against the model");
        resetFor(1);
        for (int n = 0; n < 3000; n++) begin
            logic [NS-1:1] sr;
            for (int k = 1; k < NS; k++) sr[k] = ($urandom_range(5) == 0);
            stepCycle("rand", ($urandom_range(49) == 0), sr, ($urandom_range(3) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
